// File: rtl/filter_ctrl_5x5.sv
// filter_ctrl_5x5: frame sequencer for a 5x5 convolution datapath.
//
// Walks an IMG_W x IMG_H raster, enabling the datapath on each accepted
// pixel and tagging which results are valid. Once the last pixel is accepted,
// it drains the CONV_LAT-deep pipeline and then pulses o_done.
//
// Optional feature: define FILTER_CTRL_BORDER_EN to tag every pixel as valid.
// The datapath zero-fills the borders, so the frame yields IMG_W*IMG_H results.
//
// Ports:
//   clk, rst       clock (rising edge); synchronous active-high reset
//   i_start        frame start request, honoured only in IDLE
//   i_in_valid     upstream pixel valid
//   o_in_ready     pixel accepted when high together with i_in_valid
//   i_out_ready    downstream can capture a result on the next cycle
//   o_conv_en      datapath enable (pipeline shift)
//   o_col, o_row   raster position of the current pixel
//   o_out_valid    one-cycle strobe: datapath result is valid
//   o_busy         high in RUN and DRAIN
//   o_done         one-cycle end-of-frame pulse
module filter_ctrl_5x5 #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned CONV_LAT = 1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_out_ready,
  output logic             o_conv_en,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [CNT_W-1:0] ColLast  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] RowLast  = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] WinEdge  = CNT_W'(4);
  localparam logic [3:0]       DrainLen = 4'(CONV_LAT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [3:0]          drain_q, drain_d;
  logic [CONV_LAT-1:0] tag_q, tag_d;
  logic [CONV_LAT:0]   tag_ext;
  logic                out_valid_q, out_valid_d;

  logic shift;
  logic accept;
  logic last_pix;
  logic window_ok;
  logic new_tag;

  // One shift per accepted pixel in RUN, plus CONV_LAT flush shifts in DRAIN.
  // Any downstream stall freezes the whole pipeline.
  assign shift = i_out_ready &
                 (((state_q == StRun) & i_in_valid) |
                  ((state_q == StDrain) & (drain_q < DrainLen)));
  assign accept   = (state_q == StRun) & shift;
  assign last_pix = (col_q == ColLast) & (row_q == RowLast);

`ifdef FILTER_CTRL_BORDER_EN
  assign window_ok = 1'b1;
`else
  // The 5x5 window ends at the current pixel, so it is fully inside the image
  // only after four columns and four rows have been seen.
  assign window_ok = (col_q >= WinEdge) & (row_q >= WinEdge);
`endif

  // DRAIN shifts inject 0 so that flushed slots never produce a strobe.
  assign new_tag = (state_q == StRun) & window_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StRun;
      StRun:   if (accept && last_pix) state_d = StDrain;
      StDrain: if (shift && (drain_q == DrainLen - 4'd1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counters, tag pipeline and result strobe
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    drain_d     = drain_q;
    tag_d       = tag_q;
    tag_ext     = {tag_q, new_tag};
    // The strobe marks the slot that leaves the pipeline on this shift.
    out_valid_d = shift & tag_q[CONV_LAT-1];

    if (shift) tag_d = tag_ext[CONV_LAT-1:0];

    if (accept) begin
      if (last_pix) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (state_q == StDrain) begin
      if (shift) drain_d = drain_q + 4'd1;
    end else begin
      drain_d = '0;
    end
  end

  // Outputs are masked by rst so that they are already low during the reset cycle.
  always_comb begin
    o_in_ready  = (state_q == StRun) & i_out_ready & ~rst;
    o_conv_en   = shift & ~rst;
    o_col       = rst ? '0 : col_q;
    o_row       = rst ? '0 : row_q;
    o_out_valid = out_valid_q & ~rst;
    o_busy      = ((state_q == StRun) | (state_q == StDrain)) & ~rst;
    o_done      = (state_q == StDone) & ~rst;
  end

endmodule

// File: tb/tb_filter_ctrl_5x5.sv
// Self-checking bench for filter_ctrl_5x5.
//
// Two instances are exercised one after the other:
//   - instance 0: an 8x6 frame with CONV_LAT=1
//   - instance 1: a 5x5 frame with CONV_LAT=3
// A frame-level reference model tracks:
//   - the raster position as a pixel index
//   - the result pipeline as a queue of tags
// Every output is compared with this model on every cycle.
module tb_filter_ctrl_5x5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       start = '0;
  logic [1:0]       in_valid = '0;
  logic [1:0]       out_ready = '0;
  logic [1:0]       in_ready;
  logic [1:0]       conv_en;
  logic [1:0]       out_valid;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [11:0]      col [2];
  logic [11:0]      row [2];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FILTER_CTRL_BORDER_EN
  localparam bit Border = 1'b1;
`else
  localparam bit Border = 1'b0;
`endif

  always #5 clk = ~clk;

  filter_ctrl_5x5 #(.IMG_W(8), .IMG_H(6), .CONV_LAT(1), .CNT_W(12)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start[0]),
    .i_in_valid  (in_valid[0]),
    .o_in_ready  (in_ready[0]),
    .i_out_ready (out_ready[0]),
    .o_conv_en   (conv_en[0]),
    .o_col       (col[0]),
    .o_row       (row[0]),
    .o_out_valid (out_valid[0]),
    .o_busy      (busy[0]),
    .o_done      (done[0])
  );

  filter_ctrl_5x5 #(.IMG_W(5), .IMG_H(5), .CONV_LAT(3), .CNT_W(12)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start[1]),
    .i_in_valid  (in_valid[1]),
    .o_in_ready  (in_ready[1]),
    .i_out_ready (out_ready[1]),
    .o_conv_en   (conv_en[1]),
    .o_col       (col[1]),
    .o_row       (row[1]),
    .o_out_valid (out_valid[1]),
    .o_busy      (busy[1]),
    .o_done      (done[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one complete frame on instance k and checks it cycle by cycle.
  //   rmode:    0 = ready always high, 1 = ready toggling, 2 = ready random
  //   vmode:    0 = valid always high, 1 = valid random
  //   rst_at:   pulse rst when pixel rst_at is offered (-1 = never)
  //   noise:    random i_start outside IDLE, random i_in_valid while idle
  //   exp_lat:  expected cycles from start to o_done (0 = not checked)
  //   exp_en:   expected o_conv_en count over the frame (-1 = not checked)
  task automatic run_frame(input int k, input int w, input int h, input int lat,
                           input int rmode, input int vmode, input int rst_at,
                           input bit noise, input int exp_lat, input int exp_en);
    int phase, pix, drained, strobes, ens, dones, cyc, start_cyc, idle_cnt;
    int exp_col, exp_row;
    bit q[$];
    bit exp_v, s, run, drn, rdy, v, st, r, did_rst, seen_done, oldest, tg;
    phase = 0; pix = 0; drained = 0; strobes = 0; ens = 0; dones = 0;
    cyc = 0; start_cyc = 0; idle_cnt = 0; exp_v = 1'b0;
    did_rst = 1'b0; seen_done = 1'b0;
    q = {};
    for (int i = 0; i < lat; i++) q.push_back(1'b0);

    while (!(seen_done && phase == 0) && cyc < 3000) begin
      @(negedge clk);
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom % 4 != 0);
      v   = (vmode == 0) ? 1'b1 : ($urandom % 3 != 0);
      r   = (phase == 1) && (pix == rst_at) && !did_rst;
      if (phase == 0) begin
        st = (idle_cnt >= 2);
        if (!st) v = noise ? 1'($urandom % 2) : 1'b0;
      end else begin
        st = noise ? 1'($urandom % 2) : 1'b0;
      end
      rst = r;
      start[k] = st;
      in_valid[k] = v;
      out_ready[k] = rdy;
      #1;

      run = (phase == 1) && !r;
      drn = (phase == 2) && !r;
      s   = rdy && ((run && v) || (drn && drained < lat));
      exp_col = run ? pix % w : 0;
      exp_row = run ? pix / w : 0;
      check("conv_en", int'(conv_en[k]), int'(s));
      check("in_ready", int'(in_ready[k]), int'(run && rdy));
      check("busy", int'(busy[k]), int'(run || drn));
      check("done", int'(done[k]), int'(phase == 3 && !r));
      check("out_valid", int'(out_valid[k]), int'(exp_v && !r));
      check("col", int'(col[k]), exp_col);
      check("row", int'(row[k]), exp_row);

      strobes += int'(out_valid[k]);
      ens     += int'(conv_en[k]);
      if (done[k]) begin
        dones++;
        seen_done = 1'b1;
        if (exp_lat > 0) check("done_latency", cyc - start_cyc, exp_lat);
      end

      if (r) begin
        phase = 0; pix = 0; drained = 0; exp_v = 1'b0; idle_cnt = 0;
        strobes = 0; ens = 0; did_rst = 1'b1;
        q = {};
        for (int i = 0; i < lat; i++) q.push_back(1'b0);
      end else begin
        oldest = 1'b0;
        if (s) begin
          tg = run && (Border || ((pix % w) >= 4 && (pix / w) >= 4));
          oldest = q.pop_front();
          q.push_back(tg);
        end
        exp_v = s && oldest;
        case (phase)
          0: if (st) begin phase = 1; pix = 0; start_cyc = cyc; end
             else idle_cnt++;
          1: if (s) begin
               pix++;
               if (pix == w * h) begin phase = 2; drained = 0; end
             end
          2: if (s) begin
               drained++;
               if (drained == lat) phase = 3;
             end
          default: phase = 0;
        endcase
      end
      cyc++;
    end
    rst = 1'b0;
    start[k] = 1'b0;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;

    check("frame_finished", int'(seen_done && phase == 0), 1);
    check("strobes", strobes, Border ? w * h : (w - 4) * (h - 4));
    check("done_count", dones, 1);
    if (exp_en >= 0) check("conv_en_count", ens, exp_en);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        check("rst_busy", int'(busy[k]), 0);
        check("rst_out_valid", int'(out_valid[k]), 0);
        check("rst_in_ready", int'(in_ready[k]), 0);
        check("rst_col", int'(col[k]), 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;

    // Free-running 8x6 frame: 48 + 1 enables, o_done 50 cycles after start
    run_frame(0, 8, 6, 1, 0, 0, -1, 1'b0, 50, 49);
    // Downstream ready toggling every cycle
    run_frame(0, 8, 6, 1, 1, 0, -1, 1'b0, 0, -1);
    // Random handshakes plus spurious start/valid
    run_frame(0, 8, 6, 1, 2, 1, -1, 1'b1, 0, -1);
    // Reset at pixel 20, then a full fresh frame
    run_frame(0, 8, 6, 1, 2, 1, 20, 1'b1, 0, -1);
    // Deep pipeline on a minimal frame: 25 run cycles + 3 drain cycles
    run_frame(1, 5, 5, 3, 0, 0, -1, 1'b0, 29, 28);
    for (int n = 0; n < 3; n++) run_frame(1, 5, 5, 3, 2, 1, -1, 1'b1, 0, -1);
    run_frame(1, 5, 5, 3, 2, 1, 12, 1'b1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_ctrl_5x5.md
FILTER_CTRL_5X5 -- requirements
Module: filter_ctrl_5x5

Interface
REQ-001 SHALL provide parameter IMG_W, default 640, image width in pixels (>=5).
REQ-002 SHALL provide parameter IMG_H, default 480, image height in lines (>=5).
REQ-003 SHALL provide parameter CONV_LAT, default 1, 5x5 convolution datapath latency in enable cycles (1..8).
REQ-004 SHALL provide parameter CNT_W, default 12, width of column/row counters.
REQ-005 SHALL have ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- i_start  input  1  frame start request.
- i_in_valid  input  1  upstream pixel valid.
- o_in_ready  output  1  pixel accepted when high with i_in_valid.
- i_out_ready  input  1  downstream can capture a result on the next cycle.
- o_conv_en  output  1  enable to the 5x5 convolution datapath.
- o_col  output  CNT_W  column of the current accepted pixel.
- o_row  output  CNT_W  row of the current accepted pixel.
- o_out_valid  output  1  one-cycle strobe: datapath o_y holds a valid result.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-007 IDLE->RUN SHALL occur on i_start=1; i_start in any other state SHALL be ignored.
REQ-008 Shift s SHALL be i_out_ready & ((RUN & i_in_valid) | (DRAIN & drain_cnt<CONV_LAT)); o_conv_en SHALL equal s (combinational).
REQ-009 o_in_ready SHALL be (state==RUN) & i_out_ready; upstream stalls whenever downstream stalls.
REQ-010 On each accepted pixel, col SHALL increment; at col==IMG_W-1 it SHALL wrap to 0 and row SHALL increment.
REQ-011 Accepting pixel (IMG_W-1, IMG_H-1) SHALL move RUN->DRAIN in the same edge; col/row SHALL return to 0.
REQ-012 Window-ok tag for an accepted pixel SHALL be (col>=4)&(row>=4) (window ends at current pixel).
REQ-013 A CONV_LAT-deep tag shift register SHALL advance only on s; DRAIN shifts inject tag 0.
REQ-014 o_out_valid SHALL be registered: o_out_valid <= s & tag[CONV_LAT-1]; otherwise 0.
REQ-015 DRAIN SHALL count CONV_LAT shifts, then go to DONE; stalls (i_out_ready=0) SHALL pause the drain count.
REQ-016 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-017 o_busy SHALL be 1 in RUN and DRAIN, 0 otherwise.
REQ-018 Valid results per frame SHALL equal (IMG_W-4)*(IMG_H-4) without border mode.
REQ-019 i_in_valid in IDLE, DRAIN or DONE SHALL not be accepted and SHALL not affect counters.

Reset
REQ-020 rst=1 at any clock edge, including mid-frame or mid-drain, SHALL force IDLE, col=row=0, tags=0, drain count=0.
REQ-021 During and after reset: o_conv_en=0, o_in_ready=0, o_out_valid=0, o_busy=0, o_done=0, o_col=o_row=0.
REQ-022 rst SHALL take priority over i_start in the same cycle.

Configuration
REQ-023 Macro FILTER_CTRL_BORDER_EN defined: every accepted pixel's tag SHALL be 1, yielding IMG_W*IMG_H results (border results computed by the datapath over its zero-fill).
REQ-024 FILTER_CTRL_BORDER_EN undefined: tag per REQ-012; no border results.

Verification
REQ-025 IMG_W=8, IMG_H=6, CONV_LAT=1, i_in_valid=1, i_out_ready=1 after i_start -> 48 conv_en in RUN + 1 in DRAIN, 8 o_out_valid strobes, o_done 50 cycles after start.
REQ-026 Same frame, i_out_ready toggling 1/0 -> o_in_ready and o_conv_en low on every ready-low cycle, still exactly 8 strobes, o_done once.
REQ-027 CONV_LAT=3, IMG_W=IMG_H=5 -> single o_out_valid 3 shifts after pixel (4,4); DRAIN lasts 3 shifts.
REQ-028 rst pulsed at pixel 20 of 8x6 frame -> outputs zero next cycle, state IDLE; new i_start yields a full 8-result frame.
REQ-029 FILTER_CTRL_BORDER_EN defined, 8x6 frame -> 48 o_out_valid strobes.
REQ-030 i_start during RUN and i_in_valid in IDLE -> no effect on counters, strobes or state.
